// File: rtl/mips_datapath_alu_muldiv_if.sv
// mips_datapath_alu_muldiv_if
// Request/response bundle for the HI/LO multiply-divide unit.
//   master : drives start, op, data1, data2, flush; observes busy, done,
//            div_zero, hi, lo (the issuing pipeline or a testbench)
//   slave  : the multiply-divide unit itself
// op encoding: 000 MULU, 001 MULS, 010 DIVU, 011 DIVS, 100 MTHI, 101 MTLO,
//              110/111 no-op.
interface mips_datapath_alu_muldiv_if #(
    parameter int DATA_W = 32
);
    logic              start;
    logic [2:0]        op;
    logic [DATA_W-1:0] data1;
    logic [DATA_W-1:0] data2;
    logic              flush;
    logic              busy;
    logic              done;
    logic              div_zero;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;

    modport master (
        output start, op, data1, data2, flush,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, op, data1, data2, flush,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/mips_datapath_alu_muldiv.sv
// mips_datapath_alu_muldiv
// MIPS HI/LO unit: fixed-latency multiply, restoring divide (one quotient
// bit per cycle) and MTHI/MTLO writes.
// Ports:
//   clock    : single rising-edge clock
//   reset_n  : asynchronous active-low reset, clears all state and HI/LO
//   bus      : mips_datapath_alu_muldiv_if.slave request/response bundle
// Parameters:
//   DATA_W   : operand and HI/LO width (even, >= 4)
//   MUL_LAT  : cycles from accept to the HI/LO product write (>= 1)
module mips_datapath_alu_muldiv #(
    parameter int DATA_W  = 32,
    parameter int MUL_LAT = 4
) (
    input  logic                        clock,
    input  logic                        reset_n,
    mips_datapath_alu_muldiv_if.slave   bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_FIX  = 2'd3;

    localparam logic [2:0] OP_MULU = 3'b000;
    localparam logic [2:0] OP_MULS = 3'b001;
    localparam logic [2:0] OP_DIVU = 3'b010;
    localparam logic [2:0] OP_DIVS = 3'b011;
    localparam logic [2:0] OP_MTHI = 3'b100;
    localparam logic [2:0] OP_MTLO = 3'b101;

    localparam int CNT_MAX = (DATA_W > MUL_LAT) ? DATA_W : MUL_LAT;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    logic [1:0]          state;
    logic [CNT_W-1:0]    cnt;
    logic [DATA_W-1:0]   hi_q;
    logic [DATA_W-1:0]   lo_q;
    logic                done_q;
    logic                dz_q;
    logic [2*DATA_W-1:0] prod_q;
    logic [DATA_W-1:0]   quo_q;
    logic [DATA_W-1:0]   rem_q;
    logic [DATA_W-1:0]   divisor_q;
    logic                q_neg_q;
    logic                r_neg_q;
    logic                dz_pend_q;

    logic                busy;
    logic                is_signed;
    logic [2*DATA_W-1:0] ext1;
    logic [2*DATA_W-1:0] ext2;
    logic [2*DATA_W-1:0] mul_full;
    logic [DATA_W-1:0]   abs1;
    logic [DATA_W-1:0]   abs2;
    logic [DATA_W:0]     rem_shift;
    logic [DATA_W:0]     diff;
    logic [DATA_W-1:0]   quo_fix;
    logic [DATA_W-1:0]   rem_fix;

    assign busy         = (state != S_IDLE);
    assign bus.busy     = busy;
    assign bus.done     = done_q;
    assign bus.div_zero = dz_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;

    // MULS and DIVS are the odd opcodes of each pair.
    assign is_signed = bus.op[0];

    // Sign- or zero-extending to 2*DATA_W makes the truncated product exact
    // for both signednesses, so one multiplier serves MULU and MULS.
    assign ext1 = is_signed ? {{DATA_W{bus.data1[DATA_W-1]}}, bus.data1}
                            : {{DATA_W{1'b0}}, bus.data1};
    assign ext2 = is_signed ? {{DATA_W{bus.data2[DATA_W-1]}}, bus.data2}
                            : {{DATA_W{1'b0}}, bus.data2};
    assign mul_full = ext1 * ext2;

    // The divider works on magnitudes; the most-negative value's magnitude
    // still fits as an unsigned DATA_W-bit number.
    assign abs1 = (is_signed && bus.data1[DATA_W-1]) ? -bus.data1 : bus.data1;
    assign abs2 = (is_signed && bus.data2[DATA_W-1]) ? -bus.data2 : bus.data2;

    // One restoring step: quo_q doubles as the dividend shift register,
    // its MSB feeds the partial remainder while quotient bits enter at LSB.
    assign rem_shift = {rem_q, quo_q[DATA_W-1]};
    assign diff      = rem_shift - {1'b0, divisor_q};

    assign quo_fix = q_neg_q ? -quo_q : quo_q;
    assign rem_fix = r_neg_q ? -rem_q : rem_q;

    // Results land in hi_q/lo_q only on the completing edge; flush takes
    // priority over everything, including acceptance while idle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
            prod_q    <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            divisor_q <= '0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            dz_pend_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dz_q   <= 1'b0;
            if (bus.flush) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (bus.start) begin
                            case (bus.op)
                                OP_MULU, OP_MULS: begin
                                    prod_q <= mul_full;
                                    cnt    <= CNT_W'(MUL_LAT - 1);
                                    state  <= S_MUL;
                                end
                                OP_DIVU, OP_DIVS: begin
                                    if (bus.data2 == '0) begin
                                        dz_pend_q <= 1'b1;
                                        state     <= S_FIX;
                                    end else begin
                                        dz_pend_q <= 1'b0;
                                        quo_q     <= abs1;
                                        rem_q     <= '0;
                                        divisor_q <= abs2;
                                        q_neg_q   <= is_signed &&
                                                     (bus.data1[DATA_W-1] ^ bus.data2[DATA_W-1]);
                                        r_neg_q   <= is_signed && bus.data1[DATA_W-1];
                                        cnt       <= CNT_W'(DATA_W - 1);
                                        state     <= S_DIV;
                                    end
                                end
                                OP_MTHI: hi_q <= bus.data1;
                                OP_MTLO: lo_q <= bus.data1;
                                default: ;
                            endcase
                        end
                    end
                    S_MUL: begin
                        if (cnt == '0) begin
                            {hi_q, lo_q} <= prod_q;
                            done_q       <= 1'b1;
                            state        <= S_IDLE;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    S_DIV: begin
                        if (!diff[DATA_W]) begin
                            rem_q <= diff[DATA_W-1:0];
                            quo_q <= {quo_q[DATA_W-2:0], 1'b1};
                        end else begin
                            rem_q <= rem_shift[DATA_W-1:0];
                            quo_q <= {quo_q[DATA_W-2:0], 1'b0};
                        end
                        if (cnt == '0) begin
                            state <= S_FIX;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    default: begin
                        if (!dz_pend_q) begin
                            lo_q <= quo_fix;
                            hi_q <= rem_fix;
                        end
                        done_q <= 1'b1;
                        dz_q   <= dz_pend_q;
                        state  <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
